// File: rtl/bit_serial_adder_pkg.sv
// rtl/bit_serial_adder_pkg.sv - shared types and helpers for the bit-serial adder
// Contents: state_t FSM encoding, cnt_width() bit-counter width helper.
package bit_serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must hold 0..WIDTH-1; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/full_adder_bit.sv
// rtl/full_adder_bit.sv - combinational full adder built from two half-adder stages
// Ports: a, b, ci (inputs); s (sum), co (carry-out).
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;   // first half-adder sum (propagate)
  logic g1;  // first half-adder carry (generate)
  logic g2;  // second half-adder carry

  assign p  = a ^ b;
  assign g1 = a & b;
  assign s  = p ^ ci;
  assign g2 = p & ci;
  assign co = g1 | g2;

endmodule

// File: rtl/bit_serial_adder.sv
// rtl/bit_serial_adder.sv - LSB-first bit-serial adder with valid/ready request and result ports
// Ports: clk, rst_n (sync active-low); start_valid/start_ready with a_in, b_in, cin;
//        done_valid/done_ready with sum_out, cout; busy (RUN or DONE).
module bit_serial_adder
  import bit_serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             busy
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_nxt;
  logic             carry;
  logic [CW-1:0]    bit_cnt;
  logic             last_bit;
  logic             fa_s;
  logic             fa_co;

  full_adder_bit u_fa (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  assign last_bit = (bit_cnt == CW'(WIDTH - 1));
  // New sum bit enters at the MSB so after WIDTH shifts bit 0 holds the LSB.
  assign sum_nxt  = WIDTH'({fa_s, sum_sh} >> 1);

  assign start_ready = (state == IDLE);
  assign busy        = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_valid) state_nxt = RUN;
      RUN:     if (last_bit)    state_nxt = DONE;
      DONE:    if (done_ready)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh       <= '0;
      b_sh       <= '0;
      sum_sh     <= '0;
      carry      <= 1'b0;
      bit_cnt    <= '0;
      sum_out    <= '0;
      cout       <= 1'b0;
      done_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            a_sh    <= a_in;
            b_sh    <= b_in;
            carry   <= cin;
            sum_sh  <= '0;
            bit_cnt <= '0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= sum_nxt;
          carry  <= fa_co;
          if (last_bit) begin
            sum_out    <= sum_nxt;
            cout       <= fa_co;
            done_valid <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        DONE: begin
          if (done_ready) done_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_adder.sv
// tb/tb_bit_serial_adder.sv - directed self-checking bench for bit_serial_adder (WIDTH=8 and WIDTH=2)
module tb_bit_serial_adder;

  logic       clk;
  logic       rst_n;

  logic       start_valid;
  logic       start_ready;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic       cin;
  logic [7:0] sum_out;
  logic       cout;
  logic       done_valid;
  logic       done_ready;
  logic       busy;

  logic       start_valid2;
  logic       start_ready2;
  logic [1:0] a_in2;
  logic [1:0] b_in2;
  logic       cin2;
  logic [1:0] sum_out2;
  logic       cout2;
  logic       done_valid2;
  logic       done_ready2;
  logic       busy2;

  int tests;
  int fails;

  bit_serial_adder #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a_in        (a_in),
    .b_in        (b_in),
    .cin         (cin),
    .sum_out     (sum_out),
    .cout        (cout),
    .done_valid  (done_valid),
    .done_ready  (done_ready),
    .busy        (busy)
  );

  bit_serial_adder #(.WIDTH(2)) dut2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid2),
    .start_ready (start_ready2),
    .a_in        (a_in2),
    .b_in        (b_in2),
    .cin         (cin2),
    .sum_out     (sum_out2),
    .cout        (cout2),
    .done_valid  (done_valid2),
    .done_ready  (done_ready2),
    .busy        (busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Accept one request on the WIDTH=8 instance and wait for its result.
  task automatic run_add(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic c, input logic [7:0] exp_sum, input logic exp_cout);
    int cycles;
    check({tag, "_start_ready"}, 32'(start_ready), 32'd1);
    a_in = a;
    b_in = b;
    cin  = c;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    a_in = 8'($urandom);
    b_in = 8'($urandom);
    cin  = 1'($urandom);
    cycles = 0;
    while (!done_valid && cycles < 100) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    check({tag, "_latency"}, 32'(cycles), 32'd8);
    check({tag, "_sum"}, 32'(sum_out), 32'(exp_sum));
    check({tag, "_cout"}, 32'(cout), 32'(exp_cout));
  endtask

  task automatic release_result(input string tag);
    done_ready = 1'b1;
    @(posedge clk);
    #1;
    done_ready = 1'b0;
    check({tag, "_rel_done_valid"}, 32'(done_valid), 32'd0);
    check({tag, "_rel_start_ready"}, 32'(start_ready), 32'd1);
    check({tag, "_rel_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int cycles;
    int seen;
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    start_valid = 1'b0;
    a_in = '0;
    b_in = '0;
    cin = 1'b0;
    done_ready = 1'b0;
    start_valid2 = 1'b0;
    a_in2 = '0;
    b_in2 = '0;
    cin2 = 1'b0;
    done_ready2 = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_start_ready", 32'(start_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done_valid", 32'(done_valid), 32'd0);
    check("rst_sum", 32'(sum_out), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);

    // Basic add
    run_add("basic", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
    check("basic_busy_done", 32'(busy), 32'd1);
    check("basic_start_ready_done", 32'(start_ready), 32'd0);
    release_result("basic");

    // Carry propagation
    run_add("carry1", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    release_result("carry1");
    run_add("carry2", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    release_result("carry2");

    // Backpressure with an ignored request during DONE
    run_add("bp", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        a_in = 8'hAA;
        b_in = 8'h01;
        start_valid = 1'b1;
      end else begin
        start_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      check("bp_sum_hold", 32'(sum_out), 32'h46);
      check("bp_cout_hold", 32'(cout), 32'd0);
      check("bp_done_valid", 32'(done_valid), 32'd1);
      check("bp_start_ready", 32'(start_ready), 32'd0);
    end
    start_valid = 1'b0;
    release_result("bp");
    repeat (3) @(posedge clk);
    #1;
    check("bp_ignored_busy", 32'(busy), 32'd0);

    // Reset in the middle of RUN
    a_in = 8'h0F;
    b_in = 8'h01;
    cin = 1'b0;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_busy_run", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_start_ready", 32'(start_ready), 32'd1);
    check("mid_done_valid", 32'(done_valid), 32'd0);
    check("mid_sum", 32'(sum_out), 32'd0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done_valid) seen++;
    end
    check("mid_no_result", 32'(seen), 32'd0);

    // Back-to-back requests
    run_add("b2b1", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);
    release_result("b2b1");
    run_add("b2b2", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
    release_result("b2b2");
    run_add("b2b3", 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0);
    release_result("b2b3");

    // Exhaustive WIDTH=2
    done_ready2 = 1'b0;
    for (int a = 0; a < 4; a++) begin
      for (int b = 0; b < 4; b++) begin
        for (int c = 0; c < 2; c++) begin
          logic [2:0] exp_res;
          exp_res = 3'(a + b + c);
          a_in2 = 2'(a);
          b_in2 = 2'(b);
          cin2 = 1'(c);
          start_valid2 = 1'b1;
          @(posedge clk);
          #1;
          start_valid2 = 1'b0;
          cycles = 0;
          while (!done_valid2 && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
          end
          check($sformatf("ex_lat_%0d_%0d_%0d", a, b, c), 32'(cycles), 32'd2);
          check($sformatf("ex_res_%0d_%0d_%0d", a, b, c), 32'({cout2, sum_out2}), 32'(exp_res));
          done_ready2 = 1'b1;
          @(posedge clk);
          #1;
          done_ready2 = 1'b0;
        end
      end
    end
    check("ex_idle", 32'(start_ready2), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bit_serial_adder.md
Name: bit_serial_adder

Overview:
- Sequential, LSB-first bit-serial adder for two WIDTH-bit operands plus carry-in.
- Each cycle it feeds one bit pair and the registered carry into a full-adder cell built from two half-adder stages.
- A valid/ready request port accepts operands; a valid/ready result port returns the sum and carry-out.
- Sits upstream of datapath consumers that want area-cheap addition and can tolerate WIDTH-cycle latency.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  synchronous, active-low reset.
start_valid  input  1  operands a_in/b_in/cin are valid this cycle.
start_ready  output  1  block can accept operands; high only in IDLE.
a_in  input  WIDTH  operand A.
b_in  input  WIDTH  operand B.
cin  input  1  carry-in.
sum_out  output  WIDTH  registered sum; valid while done_valid is high.
cout  output  1  registered carry-out; valid while done_valid is high.
done_valid  output  1  result available.
done_ready  input  1  consumer accepts the result.
busy  output  1  high in RUN or DONE.

Behaviour:
- One clock; reset is synchronous and active-low (clk, rst_n).
- States: IDLE, RUN, DONE. Encoding lives in the package.

Reset (rst_n low at a clock edge):
- State goes to IDLE.
- Shift registers, carry register, bit counter, sum_out, cout and done_valid all clear to 0.
- start_ready = 1 and busy = 0 after reset.
- Reset asserted during RUN or DONE abandons the operation. No result is produced.

IDLE:
- start_ready = 1.
- On a clock edge with start_valid=1:
  - a_in → a_sh, b_in → b_sh, cin → carry register.
  - Clear the bit counter and sum_sh.
  - Go to RUN.

RUN (WIDTH cycles):
- start_ready = 0. start_valid is ignored.
- Each cycle:
  - s = a_sh[0] ^ b_sh[0] ^ carry.
  - c_next = majority(a_sh[0], b_sh[0], carry).
- At the edge:
  - sum_sh shifts right with s inserted at the MSB.
  - a_sh and b_sh shift right.
  - carry ← c_next.
  - Counter increments.
- When the counter equals WIDTH-1 at an edge:
  - Transition to DONE.
  - Load sum_out with the final shifted value and cout with c_next in the same edge.
  - done_valid ← 1.

Latency:
- Operands accepted at edge k give done_valid=1 from edge k+WIDTH.

DONE:
- done_valid = 1. sum_out and cout are held stable.
- When done_ready=1 at an edge: done_valid ← 0 and state → IDLE.
- start_ready rises one cycle later; there is no same-cycle accept on the result handshake.
- With done_ready=0 the block holds indefinitely.

Arithmetic:
- {cout, sum_out} == a_in + b_in + cin, computed mod 2^(WIDTH+1).
- Counter width is $clog2(WIDTH). It never wraps past WIDTH-1.
- Operand inputs are sampled only at the accept edge. Later changes have no effect.

Decomposition:
- Package bit_serial_adder_pkg holds:
  - the state_t enum {IDLE, RUN, DONE};
  - a localparam function for counter width.
- Sub-module full_adder_bit: two half-adder stages plus an OR; ports a, b, ci, s, co; purely combinational.
- The top holds the FSM, shift registers and the carry flop, and instantiates one full_adder_bit.

Test Plan:
1. Basic add:
   - Stimulus: WIDTH=8, a=0x5A, b=0x3C, cin=0, done_ready=1.
   - Required: done_valid exactly 8 cycles after accept; sum_out=0x96, cout=0; start_ready high again 1 cycle after the result handshake.
2. Carry propagation:
   - a=0xFF, b=0x01, cin=0 → sum_out=0x00, cout=1.
   - a=0xFF, b=0xFF, cin=1 → sum_out=0xFF, cout=1.
3. Backpressure:
   - Stimulus: a=0x12, b=0x34; hold done_ready=0 for 5 cycles after done_valid; pulse start_valid with a=0xAA meanwhile.
   - Required: sum_out=0x46 stays stable, done_valid stays 1, start_ready stays 0, the 0xAA request is ignored; result releases on done_ready=1.
4. Reset mid-run:
   - Stimulus: accept a=0x0F, b=0x01; assert rst_n=0 for one edge after 3 RUN cycles.
   - Required: next cycle state IDLE, done_valid=0, sum_out=0, start_ready=1, busy=0; no result is ever produced.
5. Back-to-back:
   - Stimulus: three requests issued whenever start_ready=1: (0x01,0x01,0), (0x80,0x80,0), (0x7F,0x00,1).
   - Required results in order: (0x02,0), (0x00,1), (0x80,0); each result arrives 8 cycles after its accept.
6. Exhaustive:
   - Stimulus: WIDTH=2, all 32 combinations of a, b, cin.
   - Required: {cout, sum_out} equals a+b+cin for every case; latency is 2 cycles each.
